ex_latency_sequencer: RTL and testbench

Sequencer for the CPU's multi-cycle EX stage. It watches the operation class held in the ID/EX register and drives the pipeline-wide stall, so that each variable-latency operation occupies EX for exactly its latency in cycles. On the last EX cycle it issues a one-cycle write-back qualifier. It replaces ad-hoc per-class stall counters with one state machine, and adds an abort path and performance counters.

---
 rtl/ex_latency_sequencer.sv | 156 +++++++++++++++
 tb/tb_ex_latency_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_latency_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ex_latency_sequencer
// Brief    : Holds multi-cycle EX operations for their latency; issues the WB qualifier.
// Revision : 1.0
// ============================================================================
module ex_latency_sequencer #(
  parameter int LAT_MEM     = 2,
  parameter int LAT_ARITH   = 3,
  parameter int LAT_MULSQ   = 4,
  parameter int LAT_DIVSQRT = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issueValid,
  input  logic [2:0]           opClass,
  input  logic [4:0]           rDin,
  input  logic                 wrEnIn,
  input  logic                 kill,
  input  logic                 clearStats,
  output logic                 stall,
  output logic                 busy,
  output logic                 wbValid,
  output logic                 wbWrEn,
  output logic [4:0]           wbAddr,
  output logic                 protoErr,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic [CNT_WIDTH-1:0] opsDone
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [2:0]           r_count;
  logic [2:0]           r_class;
  logic [4:0]           r_rd;
  logic                 r_wren;
  logic                 r_proto_err;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_ops_done;

  logic [2:0]           w_cls;
  logic [2:0]           w_lat_new;
  logic [2:0]           w_lat_cur;
  logic                 w_last;

  function automatic logic [2:0] lat_of(input logic [2:0] cls);
    case (cls)
      3'd1:    return 3'(LAT_MEM);
      3'd2:    return 3'(LAT_ARITH);
      3'd3:    return 3'(LAT_MULSQ);
      3'd4:    return 3'(LAT_DIVSQRT);
      default: return 3'd1;
    endcase
  endfunction

  assign w_cls     = (opClass > 3'd4) ? 3'd0 : opClass;
  assign w_lat_new = lat_of(w_cls);
  assign w_lat_cur = lat_of(r_class);
  assign w_last    = (r_count >= (w_lat_cur - 3'd1));

  // Reset and kill both force every combinational qualifier low.
  always_comb begin
    stall   = 1'b0;
    wbValid = 1'b0;
    wbWrEn  = 1'b0;
    wbAddr  = 5'd0;
    if (reset && !kill) begin
      if (r_state == ST_BUSY) begin
        wbAddr = r_rd;
        if (w_last) begin
          wbValid = 1'b1;
          wbWrEn  = r_wren && (r_rd != 5'd0);
        end else begin
          stall = 1'b1;
        end
      end else if (issueValid) begin
        wbAddr = rDin;
        if (w_lat_new == 3'd1) begin
          wbValid = 1'b1;
          wbWrEn  = wrEnIn && (rDin != 5'd0);
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_count        <= 3'd0;
      r_class        <= 3'd0;
      r_rd           <= 5'd0;
      r_wren         <= 1'b0;
      r_proto_err    <= 1'b0;
      r_stall_cycles <= '0;
      r_ops_done     <= '0;
    end else begin
      if (kill) begin
        r_state <= ST_IDLE;
        r_count <= 3'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (issueValid && (w_lat_new != 3'd1)) begin
              r_class <= w_cls;
              r_rd    <= rDin;
              r_wren  <= wrEnIn;
              r_count <= 3'd1;
              r_state <= ST_BUSY;
            end
          end
          default: begin
            if (w_last) begin
              r_count <= 3'd0;
              r_state <= ST_IDLE;
            end else begin
              r_count <= r_count + 3'd1;
            end
          end
        endcase
      end

      // The held instruction must not change under a stall.
      if ((r_state == ST_BUSY) && ((opClass != r_class) || (rDin != r_rd))) begin
        r_proto_err <= 1'b1;
      end

      if (clearStats) begin
        r_stall_cycles <= '0;
        r_ops_done     <= '0;
      end else begin
        if (stall && !(&r_stall_cycles)) begin
          r_stall_cycles <= r_stall_cycles + C_CNT_ONE;
        end
        if (wbValid) begin
          r_ops_done <= r_ops_done + C_CNT_ONE;
        end
      end
    end
  end

  assign busy        = (r_state == ST_BUSY);
  assign protoErr    = r_proto_err;
  assign stallCycles = r_stall_cycles;
  assign opsDone     = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_ex_latency_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_latency_sequencer
// Brief    : Directed stimulus with a write-back scoreboard for ex_latency_sequencer.
// Revision : 1.0
// ============================================================================
module tb_ex_latency_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          issueValid = 1'b0;
  logic [2:0]    opClass = 3'd0;
  logic [4:0]    rDin = 5'd0;
  logic          wrEnIn = 1'b0;
  logic          kill = 1'b0;
  logic          clearStats = 1'b0;
  logic          stall;
  logic          busy;
  logic          wbValid;
  logic          wbWrEn;
  logic [4:0]    wbAddr;
  logic          protoErr;
  logic [CW-1:0] stallCycles;
  logic [CW-1:0] opsDone;

  typedef struct {
    int         cyc;
    logic       we;
    logic [4:0] addr;
  } wb_t;

  wb_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  ex_latency_sequencer #(
    .LAT_MEM(2), .LAT_ARITH(3), .LAT_MULSQ(4), .LAT_DIVSQRT(5), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .issueValid(issueValid), .opClass(opClass),
    .rDin(rDin), .wrEnIn(wrEnIn), .kill(kill), .clearStats(clearStats),
    .stall(stall), .busy(busy), .wbValid(wbValid), .wbWrEn(wbWrEn),
    .wbAddr(wbAddr), .protoErr(protoErr), .stallCycles(stallCycles), .opsDone(opsDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [2:0] cls, input logic [4:0] rd,
                      input logic we, input logic kl, input logic cs, input logic rn,
                      input logic es, input logic eb);
    issueValid = iv; opClass = cls; rDin = rd; wrEnIn = we;
    kill = kl; clearStats = cs; reset = rn;
    @(negedge clk);
    chk("stall", 32'(stall), 32'(es));
    chk("busy", 32'(busy), 32'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] cls, input logic [4:0] rd, input logic we, input int lat);
    wb_t e;
    e.cyc  = cyc + lat - 1;
    e.we   = we && (rd != 5'd0);
    e.addr = rd;
    q.push_back(e);
    for (int i = 0; i < lat; i++) begin
      step(1'b1, cls, rd, we, 1'b0, 1'b0, 1'b1, (i < lat - 1), (i > 0));
    end
  endtask

  task automatic chk_cnt(input int exp_stall, input int exp_ops);
    chk("stallCycles", 32'(stallCycles), 32'(exp_stall));
    chk("opsDone", 32'(opsDone), 32'(exp_ops));
  endtask

  task automatic clear_stats();
    step(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_cnt(0, 0);
  endtask

  initial begin
    fork
      forever begin
        wb_t e;
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc < cyc) begin
          checks++;
          errors++;
          e = q.pop_front();
          $display("FAIL wb_missing expected_cyc=%0d now=%0d", e.cyc, cyc);
        end
        if (wbValid) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected cyc=%0d got addr=%0d we=%0d exp none", cyc, wbAddr, wbWrEn);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.we !== wbWrEn || e.addr !== wbAddr) begin
              errors++;
              $display("FAIL wb_match cyc=%0d got addr=%0d we=%0d exp cyc=%0d addr=%0d we=%0d",
                       cyc, wbAddr, wbWrEn, e.cyc, e.addr, e.we);
            end
          end
        end
      end
    join_none

    // Reset held with a live issue: outputs must stay low.
    @(posedge clk); #1;
    step(1'b1, 3'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt(0, 0);
    chk("protoErr_reset", 32'(protoErr), 32'd0);

    // divsqrt, latency 5
    run_op(3'd4, 5'd7, 1'b1, 5);
    chk_cnt(4, 1);
    clear_stats();

    // mem back-to-back, second to r0
    run_op(3'd1, 5'd3, 1'b1, 2);
    run_op(3'd1, 5'd0, 1'b1, 2);
    chk_cnt(2, 2);
    clear_stats();

    // ten single-cycle ops, last with an out-of-range class
    for (int i = 0; i < 10; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      run_op((i == 9) ? 3'd6 : 3'd0, 5'(i + 1), iv[0], 1);
    end
    chk_cnt(0, 10);
    chk("protoErr_clean", 32'(protoErr), 32'd0);
    clear_stats();

    // mulsq killed in cycle 2
    step(1'b1, 3'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 3'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt(2, 0);

    // mulsq aborted by reset in cycle 2
    step(1'b1, 3'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 3'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt(0, 0);
    chk("protoErr_after_reset", 32'(protoErr), 32'd0);

    // arith with opClass changed mid-op, stats cleared on completion
    begin
      wb_t e;
      e.cyc = cyc + 2; e.we = 1'b1; e.addr = 5'd9;
      q.push_back(e);
    end
    step(1'b1, 3'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 3'd4, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("protoErr_set", 32'(protoErr), 32'd1);
    chk_cnt(0, 0);
    step(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("protoErr_sticky", 32'(protoErr), 32'd1);

    // 20 stall cycles into a 4-bit counter
    for (int k = 0; k < 5; k++) begin
      run_op(3'd4, 5'(k + 1), 1'b1, 5);
    end
    chk_cnt(15, 5);

    step(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wb_pending", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
